seq_alu: RTL and testbench
==========================

Name: seq_alu

Overview:
Parametrised, multi-cycle successor to the single-cycle datapath ALU. It performs logic and arithmetic ops in one cycle. Shifts and rotates iterate one bit position per clock, and MUL is an iterative shift-add multiplier. The result and the status flags are registered and held stable. A Start/Ready/Done handshake lets the control unit stall the pipeline while a multi-cycle op is in flight.

Parameters:
W, 8, datapath width; power of two, >= 4
AW, $clog2(W), width of the shift/mask amount field

Ports:
Clk  in  1  clock; all state updates on the rising edge
Reset_n  in  1  asynchronous, active-low reset
Start  in  1  request; accepted only when Ready=1
OP  in  4  opcode, type seq_op_t
InputA  in  W  operand A
InputB  in  W  operand B
Amount  in  AW  shift/rotate count or mask bit index
SC_in  in  1  carry-in for ADD
Ready  out  1  combinational; high only in state IDLE
Done  out  1  registered one-cycle pulse; Out and flags update in this same cycle
Out  out  W  registered result; holds until the next Done
Zero  out  1  registered, ~|Out
Parity  out  1  registered, ^Out
Odd  out  1  registered, Out[0]
Carry  out  1  registered; meaning depends on the op (see Behaviour)
Illegal  out  1  registered; set on an undefined opcode

Behaviour:
- Reset (asynchronous, any state, including mid-operation):
  - state=IDLE, accumulator=0, count=0.
  - Out=0; Zero, Parity, Odd, Carry, Illegal and Done all 0.
  - Ready=1 once Reset_n is released.
  - An op in flight is discarded; no Done is produced for it.
- Operands:
  - On the acceptance edge (Start & Ready), OP, InputA, InputB, Amount and SC_in are captured into internal registers.
  - Inputs are don't-care after acceptance.
- States: IDLE, SHIFT, MUL.
- Single-cycle ops. Start accepted at edge k -> Out, flags and Done valid after edge k; latency 1. State stays IDLE.
  - ADD: {Carry,Out} = A + B + SC_in.
  - SUB: Out = A - B; Carry = 1 when A >= B (no borrow).
  - XOR: A^B. AND: A&B. MOV: B. Carry = 0 for all three.
  - SEQ: Out = (A==B) ? 1 : 0. SNE: the inverse. Carry = 0.
  - MSK: Out = A & (1<<Amount). Carry = 0.
- Shift/rotate ops: LSL, LSR, ASR, ROL.
  - Amount=0: behaves as a single-cycle op; Out=A, Carry=0.
  - Amount=N>0: the acceptance edge loads the accumulator with A and count=N, then goes to SHIFT.
  - Each SHIFT edge shifts by 1 and decrements count.
  - The edge where count goes 1->0 writes Out, flags and Done, and returns to IDLE. Latency N+1.
  - LSL/LSR insert 0. ASR replicates the MSB. ROL wraps the MSB to the LSB.
  - Carry = the last bit shifted out (for ROL, the last bit wrapped).
- MUL:
  - Acceptance edge: product register {hi,lo} = {0, A}, count = W, go to MUL.
  - Each edge performs one shift-add step using B.
  - After W steps: Out = low W bits, Carry = |(high W bits) (overflow), Done. Latency W+1.
- Undefined opcode: single-cycle; Out=0, Illegal=1, Carry=0, Done pulses. Illegal clears on the next Done of a legal op.
- Start while Ready=0 is ignored; it is not queued.
- Back-to-back: Start may be high in the same cycle Done is high (state is IDLE), giving 1 result per cycle for single-cycle ops.
- Out and flags never change except on a Done cycle or on reset.

Decomposition:
- Shared package Definitions holds:
  - typedef enum logic[3:0] seq_op_t: ADD=0, SUB=1, XOR=2, AND=3, MOV=4, SEQ=5, SNE=6, MSK=7, LSL=8, LSR=9, ASR=10, ROL=11, MUL=12; 13-15 illegal.
  - typedef enum seq_alu_state_t {IDLE, SHIFT, MUL_RUN}.
- Natural sub-module: seq_alu_shift1. Combinational one-bit shift/rotate step (mode, data -> data, bit_out), reused by both the SHIFT and MUL iterations.

Test Plan:
- Reset mid-MUL: W=8, MUL A=8'hFF B=8'hFF started; Reset_n low 3 cycles later -> Out=0, all flags 0, no Done, Ready=1 after release.
- ADD A=8'hF0 B=8'h10 SC_in=1 -> one cycle later Done=1, Out=8'h01, Carry=1, Zero=0, Odd=1.
- LSR Amount=3 A=8'b1010_1101, Start at cycle 0:
  - Ready=0 in cycles 1-3, Done at cycle 4.
  - Out=8'h15, Carry=1.
  - A Start in cycle 2 (OP=MOV) is ignored; Out unchanged until cycle 4.
- ASR Amount=7 A=8'h80 -> Out=8'hFF after 8 cycles. ROL Amount=1 A=8'h81 -> Out=8'h03, Carry=1. LSL Amount=0 -> Out=A, latency 1.
- MUL A=8'd15 B=8'd17 -> Done after 9 cycles, Out=8'hFF, Carry=0. MUL A=8'd16 B=8'd16 -> Out=8'h00, Carry=1, Zero=1.
- Back-to-back: SEQ A=B=8'h2A, then SUB 8'h05-8'h07 started in the Done cycle -> Out=1, then Out=8'hFE, Carry=0. OP=4'd14 -> Illegal=1, Out=0; the next legal op clears Illegal.

Source files
------------

// File: rtl/seq_alu_pkg.sv
// Shared definitions for the sequential ALU.
// Contents:
//   seq_op_t        - 4-bit opcode; encodings 13..15 are undefined
//   seq_alu_state_t - top-level controller states
//   shift_mode_t    - operating mode of the one-bit shift/rotate step
//   is_shift_op     - true for the iterative shift/rotate opcodes
//   shift_mode_of   - maps a shift/rotate opcode to its step mode
package seq_alu_pkg;

    typedef enum logic [3:0] {
        ADD = 4'd0,
        SUB = 4'd1,
        XOR = 4'd2,
        AND = 4'd3,
        MOV = 4'd4,
        SEQ = 4'd5,
        SNE = 4'd6,
        MSK = 4'd7,
        LSL = 4'd8,
        LSR = 4'd9,
        ASR = 4'd10,
        ROL = 4'd11,
        MUL = 4'd12
    } seq_op_t;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        MUL_RUN
    } seq_alu_state_t;

    typedef enum logic [1:0] {
        SH_LSL,
        SH_LSR,
        SH_ASR,
        SH_ROL
    } shift_mode_t;

    function automatic logic is_shift_op(input seq_op_t op);
        return op inside {LSL, LSR, ASR, ROL};
    endfunction

    function automatic shift_mode_t shift_mode_of(input seq_op_t op);
        shift_mode_t mode;
        case (op)
            LSL:     mode = SH_LSL;
            LSR:     mode = SH_LSR;
            ASR:     mode = SH_ASR;
            default: mode = SH_ROL;
        endcase
        return mode;
    endfunction

endpackage

// File: rtl/seq_alu_shift1.sv
// One-bit shift/rotate step, purely combinational.
// Ports:
//   mode    - SH_LSL / SH_LSR / SH_ASR / SH_ROL
//   fill    - bit inserted by LSL (at the LSB) and LSR (at the MSB)
//   data    - value before the step
//   result  - value after the step
//   bit_out - bit that leaves the word (for ROL, the bit that wraps around)
module seq_alu_shift1
    import seq_alu_pkg::*;
#(
    parameter int N = 8
) (
    input  shift_mode_t  mode,
    input  logic         fill,
    input  logic [N-1:0] data,
    output logic [N-1:0] result,
    output logic         bit_out
);

    always_comb begin
        result  = data;
        bit_out = 1'b0;
        case (mode)
            SH_LSL: begin
                result  = {data[N-2:0], fill};
                bit_out = data[N-1];
            end
            SH_LSR: begin
                result  = {fill, data[N-1:1]};
                bit_out = data[0];
            end
            SH_ASR: begin
                result  = {data[N-1], data[N-1:1]};
                bit_out = data[0];
            end
            SH_ROL: begin
                result  = {data[N-2:0], data[N-1]};
                bit_out = data[N-1];
            end
            default: begin
                result  = data;
                bit_out = 1'b0;
            end
        endcase
    end

endmodule

// File: rtl/seq_alu.sv
// Multi-cycle ALU with a Start/Ready/Done handshake.
// Logic/arithmetic ops finish in one cycle; shifts and rotates step one bit
// per clock; MUL is an iterative shift-add multiplier.
// Ports:
//   Clk, Reset_n       - clock, asynchronous active-low reset
//   Start              - request, taken only while Ready is high
//   OP, InputA, InputB - opcode and operands
//   Amount             - shift/rotate count or mask bit index
//   SC_in              - carry-in for ADD
//   Ready              - high while idle (combinational)
//   Done               - one-cycle pulse; Out and flags update with it
//   Out                - registered result, held until the next Done
//   Zero/Parity/Odd    - registered status of Out
//   Carry              - op-dependent carry / last bit out / MUL overflow
//   Illegal            - set by an undefined opcode
module seq_alu
    import seq_alu_pkg::*;
#(
    parameter int W  = 8,
    parameter int AW = $clog2(W)
) (
    input  logic          Clk,
    input  logic          Reset_n,
    input  logic          Start,
    input  seq_op_t       OP,
    input  logic [W-1:0]  InputA,
    input  logic [W-1:0]  InputB,
    input  logic [AW-1:0] Amount,
    input  logic          SC_in,
    output logic          Ready,
    output logic          Done,
    output logic [W-1:0]  Out,
    output logic          Zero,
    output logic          Parity,
    output logic          Odd,
    output logic          Carry,
    output logic          Illegal
);

    localparam logic [AW:0] COUNT_ONE = (AW+1)'(1);
    localparam logic [AW:0] MUL_STEPS = (AW+1)'(W);

    seq_alu_state_t state;
    seq_op_t        op_q;
    logic [W-1:0]   acc;
    logic [W-1:0]   hi;
    logic [W-1:0]   b_q;
    logic [AW:0]    count;

    logic           accept;
    logic           starts_multi;
    logic           last_step;
    logic [W:0]     add_sum;
    logic [W:0]     mul_sum;
    logic [W-1:0]   single_out;
    logic           single_carry;
    logic           single_illegal;
    shift_mode_t    step_mode;
    logic           step_fill;
    logic [W-1:0]   step_out;
    logic           step_bit;
    logic           res_valid;
    logic [W-1:0]   res_out;
    logic           res_carry;
    logic           res_illegal;

    assign Ready        = (state == IDLE);
    assign accept       = Start & Ready;
    assign starts_multi = (OP == MUL) || (is_shift_op(OP) && (Amount != '0));
    assign last_step    = (count == COUNT_ONE);
    assign add_sum      = {1'b0, InputA} + {1'b0, InputB} + {{W{1'b0}}, SC_in};

    // MUL keeps the multiplier in acc (low half) and the partial product in
    // hi; each step conditionally adds B to hi, then the {carry,hi,acc}
    // chain shifts right by one.
    assign mul_sum = {1'b0, hi} + (acc[0] ? {1'b0, b_q} : {(W+1){1'b0}});

    // The single step unit serves both loops: in MUL it shifts the low half
    // right, pulling in the LSB of the freshly added high half.
    assign step_mode = (state == MUL_RUN) ? SH_LSR : shift_mode_of(op_q);
    assign step_fill = (state == MUL_RUN) ? mul_sum[0] : 1'b0;

    seq_alu_shift1 #(.N(W)) u_step (
        .mode    (step_mode),
        .fill    (step_fill),
        .data    (acc),
        .result  (step_out),
        .bit_out (step_bit)
    );

    // Results of the ops that complete on the acceptance edge.
    always_comb begin
        single_out     = '0;
        single_carry   = 1'b0;
        single_illegal = 1'b0;
        case (OP)
            ADD: begin
                single_out   = add_sum[W-1:0];
                single_carry = add_sum[W];
            end
            SUB: begin
                single_out   = InputA - InputB;
                single_carry = (InputA >= InputB);
            end
            XOR:                single_out = InputA ^ InputB;
            AND:                single_out = InputA & InputB;
            MOV:                single_out = InputB;
            SEQ:                single_out = {{(W-1){1'b0}}, (InputA == InputB)};
            SNE:                single_out = {{(W-1){1'b0}}, (InputA != InputB)};
            MSK:                single_out = InputA & (W'(1) << Amount);
            LSL, LSR, ASR, ROL: single_out = InputA;
            MUL:                single_out = '0;
            default:            single_illegal = 1'b1;
        endcase
    end

    // Selects which path, if any, completes on the coming edge.
    always_comb begin
        res_valid   = 1'b0;
        res_out     = '0;
        res_carry   = 1'b0;
        res_illegal = 1'b0;
        case (state)
            IDLE: begin
                if (accept && !starts_multi) begin
                    res_valid   = 1'b1;
                    res_out     = single_out;
                    res_carry   = single_carry;
                    res_illegal = single_illegal;
                end
            end
            SHIFT: begin
                if (last_step) begin
                    res_valid = 1'b1;
                    res_out   = step_out;
                    res_carry = step_bit;
                end
            end
            MUL_RUN: begin
                if (last_step) begin
                    res_valid = 1'b1;
                    res_out   = step_out;
                    res_carry = |mul_sum[W:1];
                end
            end
            default: res_valid = 1'b0;
        endcase
    end

    // Controller, iteration registers and the registered result/flags.
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            state   <= IDLE;
            op_q    <= ADD;
            acc     <= '0;
            hi      <= '0;
            b_q     <= '0;
            count   <= '0;
            Done    <= 1'b0;
            Out     <= '0;
            Zero    <= 1'b0;
            Parity  <= 1'b0;
            Odd     <= 1'b0;
            Carry   <= 1'b0;
            Illegal <= 1'b0;
        end else begin
            Done <= res_valid;
            case (state)
                IDLE: begin
                    if (accept && starts_multi) begin
                        op_q <= OP;
                        acc  <= InputA;
                        b_q  <= InputB;
                        hi   <= '0;
                        if (OP == MUL) begin
                            count <= MUL_STEPS;
                            state <= MUL_RUN;
                        end else begin
                            count <= {1'b0, Amount};
                            state <= SHIFT;
                        end
                    end
                end
                SHIFT: begin
                    acc   <= step_out;
                    count <= count - COUNT_ONE;
                    if (last_step) state <= IDLE;
                end
                MUL_RUN: begin
                    acc   <= step_out;
                    hi    <= mul_sum[W:1];
                    count <= count - COUNT_ONE;
                    if (last_step) state <= IDLE;
                end
                default: state <= IDLE;
            endcase
            if (res_valid) begin
                Out     <= res_out;
                Zero    <= ~|res_out;
                Parity  <= ^res_out;
                Odd     <= res_out[0];
                Carry   <= res_carry;
                Illegal <= res_illegal;
            end
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed testbench for seq_alu (W=8): hand-computed vectors covering
// reset, single-cycle ops, shift/rotate timing, MUL, back-to-back starts
// and undefined opcodes.
module tb_seq_alu;
    import seq_alu_pkg::*;

    localparam int W  = 8;
    localparam int AW = 3;

    logic          Clk;
    logic          Reset_n;
    logic          Start;
    seq_op_t       OP;
    logic [W-1:0]  InputA;
    logic [W-1:0]  InputB;
    logic [AW-1:0] Amount;
    logic          SC_in;
    logic          Ready;
    logic          Done;
    logic [W-1:0]  Out;
    logic          Zero;
    logic          Parity;
    logic          Odd;
    logic          Carry;
    logic          Illegal;

    int vector_count = 0;
    int miss_count   = 0;

    seq_alu #(.W(W), .AW(AW)) dut (
        .Clk     (Clk),
        .Reset_n (Reset_n),
        .Start   (Start),
        .OP      (OP),
        .InputA  (InputA),
        .InputB  (InputB),
        .Amount  (Amount),
        .SC_in   (SC_in),
        .Ready   (Ready),
        .Done    (Done),
        .Out     (Out),
        .Zero    (Zero),
        .Parity  (Parity),
        .Odd     (Odd),
        .Carry   (Carry),
        .Illegal (Illegal)
    );

    initial begin
        Clk = 1'b0;
        forever #5 Clk = ~Clk;
    end

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: simulation did not finish, observed running, expected finished");
        $fatal(1, "[TB] watchdog expired");
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        vector_count++;
        if (observed !== expected) begin
            miss_count++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Presents one request for a single cycle; returns at the falling edge
    // just after the acceptance edge.
    task automatic applyStimulus(input seq_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [AW-1:0] amt, input logic sc);
        @(negedge Clk);
        OP     = op;
        InputA = a;
        InputB = b;
        Amount = amt;
        SC_in  = sc;
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
    endtask

    task automatic runOp(input string tag, input seq_op_t op, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [AW-1:0] amt, input logic sc, input int exp_lat,
                         input logic [W-1:0] exp_out, input logic exp_carry, input logic exp_illegal);
        int lat;
        lat = 1;
        applyStimulus(op, a, b, amt, sc);
        while (Done !== 1'b1 && lat < 40) begin
            @(negedge Clk);
            lat++;
        end
        if (Done !== 1'b1) begin
            checkOutput({tag, " done timeout"}, 32'(Done), 32'd1);
        end else begin
            checkOutput({tag, " latency"}, 32'(lat), 32'(exp_lat));
            checkOutput({tag, " out"}, 32'(Out), 32'(exp_out));
            checkOutput({tag, " carry"}, 32'(Carry), 32'(exp_carry));
            checkOutput({tag, " zero"}, 32'(Zero), 32'(~|exp_out));
            checkOutput({tag, " parity"}, 32'(Parity), 32'(^exp_out));
            checkOutput({tag, " odd"}, 32'(Odd), 32'(exp_out[0]));
            checkOutput({tag, " illegal"}, 32'(Illegal), 32'(exp_illegal));
        end
        @(negedge Clk);
        checkOutput({tag, " done pulse"}, 32'(Done), 32'd0);
        checkOutput({tag, " out hold"}, 32'(Out), 32'(exp_out));
    endtask

    initial begin
        int dones;
        Reset_n = 1'b0;
        Start   = 1'b0;
        OP      = ADD;
        InputA  = '0;
        InputB  = '0;
        Amount  = '0;
        SC_in   = 1'b0;

        // Reset state
        repeat (2) @(negedge Clk);
        checkOutput("reset out", 32'(Out), 32'd0);
        checkOutput("reset flags", 32'({Zero, Parity, Odd, Carry, Illegal, Done}), 32'd0);
        Reset_n = 1'b1;
        @(negedge Clk);
        checkOutput("reset ready", 32'(Ready), 32'd1);

        // ADD with carry-in: F0 + 10 + 1 = 0x101
        runOp("add", ADD, 8'hF0, 8'h10, 3'd0, 1'b1, 1, 8'h01, 1'b1, 1'b0);

        // Reset asserted while a MUL is in flight
        applyStimulus(MUL, 8'hFF, 8'hFF, 3'd0, 1'b0);
        checkOutput("mul busy ready", 32'(Ready), 32'd0);
        repeat (2) @(negedge Clk);
        Reset_n = 1'b0;
        #1;
        checkOutput("midreset out", 32'(Out), 32'd0);
        checkOutput("midreset flags", 32'({Zero, Parity, Odd, Carry, Illegal, Done}), 32'd0);
        repeat (3) @(negedge Clk);
        Reset_n = 1'b1;
        @(negedge Clk);
        checkOutput("midreset ready", 32'(Ready), 32'd1);
        dones = 0;
        repeat (12) begin
            @(negedge Clk);
            if (Done === 1'b1) dones++;
        end
        checkOutput("midreset no done", 32'(dones), 32'd0);
        checkOutput("midreset out held", 32'(Out), 32'd0);

        // LSR by 3 with an ignored MOV request while busy
        @(negedge Clk);
        OP     = LSR;
        InputA = 8'b1010_1101;
        InputB = 8'h00;
        Amount = 3'd3;
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
        checkOutput("lsr c1 ready", 32'(Ready), 32'd0);
        checkOutput("lsr c1 done", 32'(Done), 32'd0);
        @(negedge Clk);
        checkOutput("lsr c2 ready", 32'(Ready), 32'd0);
        OP     = MOV;
        InputB = 8'h77;
        Start  = 1'b1;
        @(negedge Clk);
        Start  = 1'b0;
        checkOutput("lsr c3 ready", 32'(Ready), 32'd0);
        checkOutput("lsr c3 out", 32'(Out), 32'd0);
        @(negedge Clk);
        checkOutput("lsr c4 done", 32'(Done), 32'd1);
        checkOutput("lsr c4 out", 32'(Out), 32'h15);
        checkOutput("lsr c4 carry", 32'(Carry), 32'd1);
        checkOutput("lsr c4 ready", 32'(Ready), 32'd1);
        @(negedge Clk);
        checkOutput("lsr c5 done", 32'(Done), 32'd0);
        checkOutput("lsr c5 out", 32'(Out), 32'h15);

        // Shift/rotate corner cases
        runOp("asr7", ASR, 8'h80, 8'h00, 3'd7, 1'b0, 8, 8'hFF, 1'b0, 1'b0);
        runOp("rol1", ROL, 8'h81, 8'h00, 3'd1, 1'b0, 2, 8'h03, 1'b1, 1'b0);
        runOp("lsl0", LSL, 8'h5A, 8'h00, 3'd0, 1'b0, 1, 8'h5A, 1'b0, 1'b0);
        runOp("lsl3", LSL, 8'b1011_0001, 8'h00, 3'd3, 1'b0, 4, 8'h88, 1'b1, 1'b0);

        // Multiplier: no overflow, then overflow with zero low half
        runOp("mul15x17", MUL, 8'd15, 8'd17, 3'd0, 1'b0, 9, 8'hFF, 1'b0, 1'b0);
        runOp("mul16x16", MUL, 8'd16, 8'd16, 3'd0, 1'b0, 9, 8'h00, 1'b1, 1'b0);

        // Assorted single-cycle ops
        runOp("msk5", MSK, 8'hFF, 8'h00, 3'd5, 1'b0, 1, 8'h20, 1'b0, 1'b0);
        runOp("sne", SNE, 8'h03, 8'h03, 3'd0, 1'b0, 1, 8'h00, 1'b0, 1'b0);
        runOp("subge", SUB, 8'h07, 8'h05, 3'd0, 1'b0, 1, 8'h02, 1'b1, 1'b0);
        runOp("xor", XOR, 8'hA5, 8'h0F, 3'd0, 1'b0, 1, 8'hAA, 1'b0, 1'b0);

        // Back-to-back: SUB requested in the SEQ Done cycle
        @(negedge Clk);
        OP     = SEQ;
        InputA = 8'h2A;
        InputB = 8'h2A;
        Amount = 3'd0;
        Start  = 1'b1;
        @(negedge Clk);
        checkOutput("b2b seq done", 32'(Done), 32'd1);
        checkOutput("b2b seq out", 32'(Out), 32'd1);
        checkOutput("b2b seq ready", 32'(Ready), 32'd1);
        OP     = SUB;
        InputA = 8'h05;
        InputB = 8'h07;
        @(negedge Clk);
        Start  = 1'b0;
        checkOutput("b2b sub done", 32'(Done), 32'd1);
        checkOutput("b2b sub out", 32'(Out), 32'hFE);
        checkOutput("b2b sub carry", 32'(Carry), 32'd0);
        checkOutput("b2b sub parity", 32'(Parity), 32'd1);

        // Undefined opcode, then a legal op clears Illegal
        runOp("illegal14", seq_op_t'(4'd14), 8'h12, 8'h34, 3'd0, 1'b0, 1, 8'h00, 1'b0, 1'b1);
        runOp("movclear", MOV, 8'h00, 8'h3C, 3'd0, 1'b0, 1, 8'h3C, 1'b0, 1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", vector_count, miss_count);
        $finish;
    end

endmodule
